// File: rtl/uart_rx_axis_master_if.sv
// AXI-Stream handshake bundle carried by the UART receiver's output.
interface uart_rx_axis_master_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_ready;

  modport master (output m_axis_data, output m_axis_valid, input m_axis_ready);
  modport slave  (input m_axis_data, input m_axis_valid, output m_axis_ready);
endinterface

// File: rtl/uart_rx_axis_master.sv
// 8N1 UART receiver with a single-entry AXI-Stream output register.
// Mid-bit sampling from the start-edge; framing errors and overruns pulse for one cycle.
module uart_rx_axis_master #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_axis_master_if.master  m_axis,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // START waits half a bit; DATA/STOP wait a full bit between samples.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             rx_s;
  logic             xfer;

  assign rx_s = sync_q[1];
  assign xfer = valid_q & m_axis.m_axis_ready;

  // Next-state logic: synchronizer, receive FSM, output register and handshake.
  always_comb begin
    sync_d  = {sync_q[0], rx};
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~xfer;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          // A start bit that is gone by mid-bit was only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          // LSB arrives first, so new bits enter at the top and walk down.
          shift_d = WIDTH'({rx_s, shift_q} >> 1);
          if (bit_q == DATA_LAST) state_d = STOP;
          else                    bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          state_d = IDLE;
          if (!rx_s) begin
            fe_d = 1'b1;
          end else if (valid_q && !xfer) begin
            ov_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any frame without an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign m_axis.m_axis_data  = data_q;
  assign m_axis.m_axis_valid = valid_q;
  assign frame_err           = fe_q;
  assign overrun             = ov_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_uart_rx_axis_master.sv
// Directed + randomized bench for uart_rx_axis_master (WIDTH=8, CLKS_PER_BIT=16).
module tb_uart_rx_axis_master;
  localparam int W = 8;
  localparam int C = 16;
  localparam int FRAME = (W + 2) * C;
  // Line driven at edge N -> outputs visible after edge N + LAT:
  // 2 sync flops, half bit, W data bits + stop bit, 1 output register.
  localparam int LAT = 2 + C / 2 + (W + 1) * C + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_axis_master_if #(.WIDTH(W)) axis ();

  uart_rx_axis_master #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_axis    (axis),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W-1:0] xfer_q[$];
  logic [W-1:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, hold_err = 0, width_err = 0;
  int exp_fe = 0, exp_ov = 0;
  logic pv = 1'b0, pfe = 1'b0, pov = 1'b0;
  logic [W-1:0] pd = '0;

  // Monitor: log transfers and pulses, watch data stability and pulse width.
  always @(negedge clk) begin
    if (rst) begin
      pv  <= 1'b0;
      pfe <= 1'b0;
      pov <= 1'b0;
    end else begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if ((frame_err && pfe) || (overrun && pov)) width_err <= width_err + 1;
      if (pv && (!axis.m_axis_valid || axis.m_axis_data !== pd)) hold_err <= hold_err + 1;
      if (axis.m_axis_valid && axis.m_axis_ready) xfer_q.push_back(axis.m_axis_data);
      pv  <= axis.m_axis_valid && !axis.m_axis_ready;
      pd  <= axis.m_axis_data;
      pfe <= frame_err;
      pov <= overrun;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Advance to just after rising edge number c.
  task automatic go_edge(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to the falling edge following rising edge number c.
  task automatic at_neg(input int c);
    go_edge(c);
    @(negedge clk);
    if (cyc != c) begin
      n_chk++;
      $error("FAIL sync: observed cycle %0d expected %0d", cyc, c);
    end
  endtask

  // Serial frame: start 0, data LSB first, stop bit as given; line idles high after.
  task automatic send_frame(input logic [W-1:0] d, input logic stopb);
    logic [W+1:0] f;
    f = {stopb, d, 1'b0};
    for (int i = 0; i < W + 2; i++) begin
      rx = f[i];
      repeat (C) begin
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d);
    chk({tag, "_valid"}, axis.m_axis_valid, v);
    if (v) chk({tag, "_data"}, axis.m_axis_data, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, gap;
    logic [W-1:0] d;
    logic good;
    axis.m_axis_ready = 1'b0;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_valid", axis.m_axis_valid, 0);
    chk("rst_data",  axis.m_axis_data, 0);
    chk("rst_busy",  busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_fe", frame_err, 0);
    chk("idle_ov", overrun, 0);

    // 1. Basic receive
    axis.m_axis_ready = 1'b1;
    n0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        at_neg(n0 + LAT - 1);
        chk("t1_pre_valid", axis.m_axis_valid, 0);
        at_neg(n0 + LAT);
        chk_out("t1", 1'b1, 8'hA5);
        chk("t1_fe", frame_err, 0);
        chk("t1_ov", overrun, 0);
        at_neg(n0 + LAT + 1);
        chk("t1_drop", axis.m_axis_valid, 0);
      end
    join
    exp_q.push_back(8'hA5);

    // 2. Back-to-back with backpressure -> overrun, old word kept
    axis.m_axis_ready = 1'b0;
    go_edge(cyc + 1);
    n0 = cyc;
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
      end
      begin
        at_neg(n0 + LAT);
        chk_out("t2_first", 1'b1, 8'h3C);
        at_neg(n0 + FRAME + LAT);
        chk("t2_ov", overrun, 1);
        chk_out("t2_keep", 1'b1, 8'h3C);
        at_neg(n0 + FRAME + LAT + 1);
        chk("t2_ov_end", overrun, 0);
        chk_out("t2_keep2", 1'b1, 8'h3C);
      end
    join
    exp_ov++;
    axis.m_axis_ready = 1'b1;
    at_neg(cyc);
    at_neg(cyc + 1);
    axis.m_axis_ready = 1'b0;
    chk("t2_drop", axis.m_axis_valid, 0);
    exp_q.push_back(8'h3C);

    // 3. Transfer in the same cycle as the stop sample
    go_edge(cyc + 1);
    n0 = cyc;
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
      end
      begin
        go_edge(n0 + FRAME + LAT - 1);
        axis.m_axis_ready = 1'b1;
        at_neg(n0 + FRAME + LAT - 1);
        chk_out("t3_old", 1'b1, 8'h3C);
        go_edge(n0 + FRAME + LAT);
        axis.m_axis_ready = 1'b0;
        at_neg(n0 + FRAME + LAT);
        chk_out("t3_new", 1'b1, 8'hC3);
        chk("t3_ov", overrun, 0);
      end
    join
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    axis.m_axis_ready = 1'b1;
    at_neg(cyc + 1);
    chk("t3_drop", axis.m_axis_valid, 0);

    // 4. Framing error, then a good frame
    go_edge(cyc + 1);
    n0 = cyc;
    fork
      send_frame(8'h55, 1'b0);
      begin
        at_neg(n0 + LAT);
        chk("t4_fe", frame_err, 1);
        chk("t4_valid", axis.m_axis_valid, 0);
        at_neg(n0 + LAT + 1);
        chk("t4_fe_end", frame_err, 0);
      end
    join
    exp_fe++;
    go_edge(cyc + 2 * C);
    n1 = cyc;
    fork
      send_frame(8'h0F, 1'b1);
      begin
        at_neg(n1 + LAT);
        chk_out("t4_next", 1'b1, 8'h0F);
        chk("t4_next_fe", frame_err, 0);
      end
    join
    exp_q.push_back(8'h0F);

    // 5. Start glitch: 4 clocks low
    go_edge(cyc + C);
    n0 = cyc;
    rx = 1'b0;
    at_neg(n0 + 2);
    chk("t5_busy_t0", busy, 0);
    at_neg(n0 + 3);
    chk("t5_busy_on", busy, 1);
    go_edge(n0 + 4);
    rx = 1'b1;
    at_neg(n0 + 2 + C / 2);
    chk("t5_busy_hold", busy, 1);
    at_neg(n0 + 3 + C / 2);
    chk("t5_busy_off", busy, 0);
    at_neg(n0 + 3 * C);
    chk("t5_valid", axis.m_axis_valid, 0);
    chk("t5_fe_cnt", fe_cnt, exp_fe);
    chk("t5_ov_cnt", ov_cnt, exp_ov);

    // 6. Reset during data bit 3
    go_edge(cyc + 1);
    n0 = cyc;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        go_edge(n0 + 4 * C + C / 2);
        rst = 1'b1;
        go_edge(n0 + 4 * C + C / 2 + 1);
        rst = 1'b0;
        at_neg(n0 + 4 * C + C / 2 + 1);
        chk("t6_valid", axis.m_axis_valid, 0);
        chk("t6_data", axis.m_axis_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fe", frame_err, 0);
        chk("t6_ov", overrun, 0);
      end
    join
    go_edge(cyc + C);
    n0 = cyc;
    fork
      send_frame(8'h81, 1'b1);
      begin
        at_neg(n0 + LAT);
        chk_out("t6_next", 1'b1, 8'h81);
        chk("t6_next_fe", frame_err, 0);
      end
    join
    exp_q.push_back(8'h81);

    // Randomized frames against the frame-level model
    for (int k = 0; k < 8; k++) begin
      d    = W'($urandom);
      good = ($urandom_range(0, 3) != 0);
      go_edge(cyc + 1);
      n0 = cyc;
      fork
        send_frame(d, good);
        begin
          at_neg(n0 + LAT);
          if (good) begin
            chk_out("rnd", 1'b1, d);
            chk("rnd_fe0", frame_err, 0);
          end else begin
            chk("rnd_fe1", frame_err, 1);
            chk("rnd_valid0", axis.m_axis_valid, 0);
          end
        end
      join
      if (good) exp_q.push_back(d);
      else      exp_fe++;
      gap = $urandom_range(0, C) + (good ? 0 : 2 * C);
      go_edge(cyc + gap);
    end

    // Totals
    go_edge(cyc + 2 * C);
    chk("fe_total", fe_cnt, exp_fe);
    chk("ov_total", ov_cnt, exp_ov);
    chk("xfer_count", xfer_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < xfer_q.size(); i++)
      chk("xfer_word", xfer_q[i], exp_q[i]);
    chk("hold_stable", hold_err, 0);
    chk("pulse_width", width_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_axis_master.md
Name: uart_rx_axis_master

Overview:
- UART receiver producing an AXI-Stream master output: the receive-direction counterpart of the AXI-Stream-to-UART transmit path.
- Samples an asynchronous serial line (8N1, LSB first) and assembles each frame into a data word.
- Presents each word on a single-entry AXI-Stream output register with valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- WIDTH, 8, data bits per frame and m_axis_data width.
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range is 4 or greater.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- m_axis_data  output  WIDTH  received word, bit 0 = first data bit on the line.
- m_axis_valid  output  1  output register holds an unconsumed word.
- m_axis_ready  input  1  downstream accepts the word when high with m_axis_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; word discarded.
- overrun  output  1  one-cycle pulse: word completed while the output was still full; new word discarded.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock; synchronous, active-high reset.
  - Output values: m_axis_data=0, m_axis_valid=0, frame_err=0, overrun=0, busy=0.
  - Internal state: FSM=IDLE, counters=0, synchronizer flops=1.
  - Reset mid-frame abandons the frame with no error pulse.
- Synchronizer: rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only (2-cycle pin latency).
- FSM states: IDLE, START, DATA, STOP. Let t0 be the first cycle in IDLE with rx_s=0.
- IDLE:
  - When rx_s=0: go to START and clear the bit counter.
  - busy goes high from t0+1.
- START:
  - Wait until t0 + CLKS_PER_BIT/2 (integer division), then sample rx_s.
  - If rx_s=1: treat as a glitch and return to IDLE silently.
  - If rx_s=0: go to DATA and reset the baud counter.
- DATA:
  - Data bit i (i=0..WIDTH-1) is sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
  - Samples shift into the shift register LSB-first.
  - After bit WIDTH-1, go to STOP.
- STOP:
  - Sample at t0 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT.
  - Return to IDLE on the next cycle, mid-stop-bit, so back-to-back frames are captured.
- Stop bit = 1, output empty (or freed in the same cycle, see below):
  - m_axis_data loads the shift register.
  - m_axis_valid=1 on the cycle after the stop sample.
- Stop bit = 1, output full and not freed this cycle:
  - overrun pulses for 1 cycle.
  - m_axis_data and m_axis_valid stay unchanged; the old word is kept.
- Stop bit = 0:
  - frame_err pulses for 1 cycle.
  - Word discarded; output register untouched.
- Handshake:
  - A transfer occurs on a cycle with m_axis_valid && m_axis_ready; m_axis_valid clears next cycle unless a new word loads.
  - Stop-bit completion with a transfer in the same cycle: the new word loads, m_axis_valid stays 1, no overrun.
  - Once m_axis_valid=1, m_axis_data is stable until the transfer completes.
  - m_axis_ready is ignored while m_axis_valid=0.
- Counters:
  - Baud counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each sample point.
  - Bit counter runs 0..WIDTH-1.
- The line is never sampled in IDLE other than for start detection. A line held low continuously causes a frame_err per frame.

Test Plan (CLKS_PER_BIT=16, WIDTH=8):
1. Basic receive: m_axis_ready=1, send 0xA5 -> m_axis_valid high 1 cycle after the stop sample; m_axis_data=0xA5; valid drops the next cycle; no error pulses.
2. Back-to-back with backpressure: send 0x3C then 0xC3, ready=0 until after the second stop sample -> overrun pulses once; the output still holds 0x3C. Then ready=1 -> 0x3C transfers and valid drops.
3. Simultaneous free: ready=0 until the exact cycle of the second frame's stop sample, then 1 for that cycle -> 0x3C transfers, 0xC3 loads, valid stays 1, no overrun.
4. Framing error: send 0x55 with the stop bit driven 0 -> frame_err 1-cycle pulse; valid stays 0. The next valid frame 0x0F is received correctly.
5. Start glitch: rx low for 4 clk then high -> FSM returns to IDLE; busy falls; no valid, frame_err or overrun.
6. Reset mid-frame: assert rst during data bit 3 of 0xFF, then send 0x81 -> all outputs 0 after reset; next output word 0x81 with no error pulses.
